capture_ctrl: RTL and testbench
===============================

# capture_ctrl

Capture sequencer for the oscilloscope sample buffer. It drives the single-port sync-write/async-read sample RAM as a circular buffer: it fills a programmable pre-trigger window, waits for a level/edge trigger, then completes the post-trigger window. After capture it streams all `DEPTH` samples out, oldest first, over a valid/ready port. It sits between the ADC sample stream and the host readout logic, and is the only master of the RAM.

## Interface
- `DATA_WIDTH`, default 8: sample width; must match the RAM.
- `ADDR_WIDTH`, default 8: RAM address width; `DEPTH = 1<<ADDR_WIDTH`.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sample_in`  in  DATA_WIDTH  ADC sample, unsigned.
- `sample_valid`  in  1  qualifies `sample_in` for one cycle.
- `arm`  in  1  pulse; starts a capture (accepted in IDLE only).
- `abort`  in  1  returns to IDLE from any state.
- `force_trig`  in  1  software trigger; honoured in ARMED only.
- `trig_level`  in  DATA_WIDTH  trigger threshold, unsigned.
- `trig_falling`  in  1  0 = rising edge, 1 = falling edge.
- `pretrig`  in  ADDR_WIDTH  pre-trigger sample count; sampled on `arm`.
- `ram_addr_in`  out  ADDR_WIDTH  RAM write address.
- `ram_data_in`  out  DATA_WIDTH  RAM write data.
- `ram_addr_out`  out  ADDR_WIDTH  RAM read address.
- `ram_data_out`  in  DATA_WIDTH  RAM async read data.
- `ram_cs`, `ram_we`, `ram_oe`  out  1 each  RAM controls.
- `rd_data`  out  DATA_WIDTH  readout sample.
- `rd_valid`  out  1  readout valid.
- `rd_ready`  in  1  readout ready.
- `rd_last`  out  1  marks the final (`DEPTH`-th) readout sample.
- `busy`  out  1  asserted in PRE, ARMED and POST.
- `triggered`  out  1  asserted from the trigger sample until IDLE.
- `done`  out  1  asserted in READ.

## Operation
- **States**
  - IDLE → PRE on `arm`. Clears `wr_ptr` and `pre_cnt`, latches `pretrig`, clears `prev_valid`.
  - PRE writes each valid sample. Moves to ARMED when `pre_cnt + 1 == pretrig` on a write. Moves immediately to ARMED if `pretrig == 0`.
  - ARMED writes each valid sample, wrapping `wr_ptr` modulo `DEPTH` (circular overwrite).
  - Trigger condition: a valid sample with `prev_valid` and `prev < trig_level <= sample` (rising), or `prev >= trig_level > sample` (falling). `force_trig` also triggers, using the same cycle's valid sample, or the next valid sample if none is present.
  - On trigger the trigger sample is written, `post_cnt` is loaded with `DEPTH-1-pretrig_latched`, `triggered` is set, and the FSM enters POST. If `post_cnt == 0`, it goes straight to READ.
  - POST writes each valid sample and decrements `post_cnt`. Enters READ after the write that takes `post_cnt` to 0.
  - READ: `rd_ptr` is loaded with the final `wr_ptr`, which is the oldest sample. `rd_cnt` is cleared.
- **Writes:** when `sample_valid` is high in PRE/ARMED/POST, then `ram_we = 1`, `ram_addr_in = wr_ptr`, `ram_data_in = sample_in` (combinational), and `wr_ptr` increments on that edge. `prev` updates on every valid sample in PRE/ARMED.
- **Readout:**
  - In READ: `ram_oe = 1`, `ram_addr_out = rd_ptr`, `rd_data = ram_data_out`, `rd_valid = 1`.
  - When `rd_valid && rd_ready`: `rd_ptr` increments (wrapping) and `rd_cnt` increments.
  - `rd_last = (rd_cnt == DEPTH-1)`. The handshake on the last sample returns the FSM to IDLE.
- **RAM controls:** `ram_cs` is high in every state except IDLE. `ram_we` is 0 outside the write states.
- **Out-of-range `pretrig`:** `pretrig >= DEPTH` cannot occur, because the width is `ADDR_WIDTH`. `pretrig = DEPTH-1` is legal and leaves zero post samples.
- **Precedence:**
  - `rst_n` low beats `abort`; `abort` beats all other inputs.
  - `abort` or reset mid-capture or mid-readout: IDLE on the next edge, with no write in that cycle.
  - RAM contents are not cleared.
  - `arm` outside IDLE is ignored.

## Timing
- **Reset values:** state IDLE, all pointers/counters 0, and every output 0. RAM data/address outputs are 0.
- **Write latency:** the sample is written on the same edge it is valid. Zero added latency.
- **Trigger latency:** the trigger sample's edge sets `triggered`, which is visible the next cycle.
- **Readout:** `rd_data` is combinational from the registered `rd_ptr`, so it is valid in the same cycle `rd_valid` rises. With `rd_ready` held high, one sample is transferred per cycle and the full readout takes `DEPTH` cycles.
- **Stalls:** `rd_valid`/`rd_data` are held stable while `rd_ready` is low.
- **Re-arm:** `done` drops the cycle after the last handshake, and `arm` is accepted from then on.

## Structure
- **Package `capture_pkg`:** holds the state enum (IDLE, PRE, ARMED, POST, READ) and the `EDGE_RISING`/`EDGE_FALLING` constants.
- **Sub-module `trig_detect`:** contains the `prev`/`prev_valid` register and the comparators. Its outputs are `hit` (combinational) and `prev_valid`, and it is cleared on `arm`/`abort`.
- **Top level:** the FSM, pointers, counters and RAM muxing stay in `capture_ctrl`.

## Test plan
- **Pre-trigger capture and readout.** Setup: DEPTH=256, `pretrig=16`, rising edge, level 0x80, ramp 0x00..0xFF valid every cycle, arm at t0. Required: trigger on sample 0x80; `triggered` rises; readout of 256 samples equals stream values 0x70..0x16F mod 256 in order; `rd_last` only on the 256th.
- **Circular overwrite before trigger.** Setup: `pretrig=4`, 1000 samples below level, then a crossing. Required: readout starts with the 4 samples preceding the trigger, then the trigger sample.
- **Falling edge with sparse valid and backpressure.** Setup: falling edge, `sample_valid` every 3rd cycle, `rd_ready` toggling. Required: no write without `sample_valid`; `rd_data` stable during stalls; full sequence correct.
- **Window boundaries.** Cases: `pretrig=0` with `force_trig`, and `pretrig=255`. Required: the first readout is the trigger sample or the 255 pre samples plus the trigger respectively; POST is skipped for 255.
- **Abort and re-arm.** Stimulus: `abort` in ARMED, POST and mid-READ; `arm` during READ. Required: IDLE next cycle, all status outputs 0, `arm` ignored during READ, and a subsequent arm captures normally.
- **Reset during POST.** Stimulus: `rst_n=0` for one cycle. Required: all outputs 0 on the next edge and `ram_we` never asserted while reset is low.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared definitions for the capture sequencer.
//   state_t      : sequencer states
//   EDGE_RISING  : trig_falling value selecting a rising-edge trigger
//   EDGE_FALLING : trig_falling value selecting a falling-edge trigger
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    READ  = 3'd4
  } state_t;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/trig_detect.sv
// Level-crossing trigger detector. Remembers the previous valid sample and
// compares it with the current one against trig_level.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   clear         : forget the previous sample (arm / abort)
//   update        : capture phase in which samples feed the history
//   sample_in     : current sample, qualified by sample_valid
//   trig_level    : threshold (unsigned)
//   trig_falling  : edge select (EDGE_RISING / EDGE_FALLING)
//   hit           : crossing seen on the current valid sample (combinational,
//                   not yet qualified by prev_valid)
//   prev_valid    : a previous sample is held
module trig_detect
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  update,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_falling,
  output logic                  hit,
  output logic                  prev_valid
);

  logic [DATA_WIDTH-1:0] prev;
  logic                  rise;
  logic                  fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (update && sample_valid) begin
      prev       <= sample_in;
      prev_valid <= 1'b1;
    end
  end

  assign rise = (prev < trig_level) && (trig_level <= sample_in);
  assign fall = (prev >= trig_level) && (trig_level > sample_in);
  assign hit  = sample_valid && ((trig_falling == EDGE_RISING) ? rise : fall);

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer for the oscilloscope sample buffer. Runs the sample RAM
// as a circular buffer: pre-trigger fill, wait for trigger, post-trigger
// fill, then streams all DEPTH samples out oldest-first on valid/ready.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   sample_in, sample_valid    : ADC stream
//   arm, abort, force_trig     : control
//   trig_level, trig_falling   : trigger setup
//   pretrig                    : pre-trigger sample count, latched on arm
//   ram_*                      : single-port RAM (sync write, async read)
//   rd_data/valid/ready/last   : readout stream
//   busy, triggered, done      : status
//
// state | meaning
// IDLE  | waiting for arm
// PRE   | filling the pre-trigger window
// ARMED | circular writes, looking for the trigger
// POST  | filling the post-trigger window
// READ  | streaming the buffer out, oldest first
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  force_trig,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_falling,
  input  logic [ADDR_WIDTH-1:0] pretrig,
  output logic [ADDR_WIDTH-1:0] ram_addr_in,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] pre_cnt;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [ADDR_WIDTH-1:0] pretrig_l;
  logic                  force_pend;
  logic                  hit;
  logic                  prev_valid;
  logic                  capturing;
  logic                  wr_en;
  logic                  trig_now;
  logic                  det_clear;
  logic                  det_update;

  trig_detect #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_trig (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (det_clear),
    .update      (det_update),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .trig_level  (trig_level),
    .trig_falling(trig_falling),
    .hit         (hit),
    .prev_valid  (prev_valid)
  );

  assign capturing  = (state == PRE) || (state == ARMED) || (state == POST);
  // Reset and abort both suppress the write of the cycle they occur in.
  assign wr_en      = rst_n && !abort && capturing && sample_valid;
  assign det_clear  = abort || ((state == IDLE) && arm);
  assign det_update = (state == PRE) || (state == ARMED);
  // A software trigger with no sample present stays pending until the next
  // valid sample, which then becomes the trigger sample.
  assign trig_now   = (state == ARMED) && sample_valid &&
                      ((hit && prev_valid) || force_trig || force_pend);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      rd_cnt     <= '0;
      pretrig_l  <= '0;
      force_pend <= 1'b0;
      triggered  <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      force_pend <= 1'b0;
      triggered  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state      <= PRE;
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            pretrig_l  <= pretrig;
            force_pend <= 1'b0;
          end
        end
        PRE: begin
          if (sample_valid) begin
            wr_ptr  <= wr_ptr + ONE;
            pre_cnt <= pre_cnt + ONE;
          end
          if ((pretrig_l == '0) || (sample_valid && (pre_cnt + ONE == pretrig_l)))
            state <= ARMED;
        end
        ARMED: begin
          if (sample_valid)
            wr_ptr <= wr_ptr + ONE;
          if (trig_now) begin
            triggered  <= 1'b1;
            force_pend <= 1'b0;
            post_cnt   <= LAST_IDX - pretrig_l;
            if (pretrig_l == LAST_IDX) begin
              // no post window; the slot after the trigger write is the oldest
              state  <= READ;
              rd_ptr <= wr_ptr + ONE;
              rd_cnt <= '0;
            end else begin
              state <= POST;
            end
          end else if (force_trig) begin
            force_pend <= 1'b1;
          end
        end
        POST: begin
          if (sample_valid) begin
            wr_ptr   <= wr_ptr + ONE;
            post_cnt <= post_cnt - ONE;
            if (post_cnt == ONE) begin
              state  <= READ;
              rd_ptr <= wr_ptr + ONE;
              rd_cnt <= '0;
            end
          end
        end
        READ: begin
          if (rd_ready) begin
            rd_ptr <= rd_ptr + ONE;
            rd_cnt <= rd_cnt + ONE;
            if (rd_cnt == LAST_IDX) begin
              state     <= IDLE;
              triggered <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ram_we       = wr_en;
  assign ram_addr_in  = wr_en ? wr_ptr : '0;
  assign ram_data_in  = wr_en ? sample_in : '0;
  assign ram_cs       = (state != IDLE);
  assign ram_oe       = (state == READ);
  assign ram_addr_out = (state == READ) ? rd_ptr : '0;
  assign rd_data      = (state == READ) ? ram_data_out : '0;
  assign rd_valid     = (state == READ);
  assign rd_last      = (state == READ) && (rd_cnt == LAST_IDX);
  assign busy         = capturing;
  assign done         = (state == READ);

endmodule

// File: tb/tb_capture_ctrl.sv
module tb_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       arm;
  logic       abort;
  logic       force_trig;
  logic [7:0] trig_level;
  logic       trig_falling;
  logic [7:0] pretrig;
  logic [7:0] ram_addr_in;
  logic [7:0] ram_data_in;
  logic [7:0] ram_addr_out;
  logic [7:0] ram_data_out;
  logic       ram_cs;
  logic       ram_we;
  logic       ram_oe;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       rd_last;
  logic       busy;
  logic       triggered;
  logic       done;

  int total;
  int bad;
  logic [7:0] stim[$];
  logic [7:0] sb[$];
  logic [7:0] mem[256];

  always #5 clk = ~clk;

  capture_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .arm(arm), .abort(abort), .force_trig(force_trig), .trig_level(trig_level),
    .trig_falling(trig_falling), .pretrig(pretrig), .ram_addr_in(ram_addr_in),
    .ram_data_in(ram_data_in), .ram_addr_out(ram_addr_out), .ram_data_out(ram_data_out),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last), .busy(busy),
    .triggered(triggered), .done(done)
  );

  // sample RAM: synchronous write, asynchronous read
  always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr_in] <= ram_data_in;
  assign ram_data_out = mem[ram_addr_out];

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    sample_valid = v;
    sample_in    = d;
    #1;
  endtask

  task automatic start_arm(input int pt, input logic [7:0] lvl, input logic fall);
    @(negedge clk);
    pretrig = 8'(pt); trig_level = lvl; trig_falling = fall;
    sample_valid = 1'b0; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Arms, streams stim[], and checks writes/status against a trigger point the
  // bench finds itself; fills sb with the 256 samples the readout must return.
  task automatic run_capture(input int pt, input logic [7:0] lvl, input logic fall,
                             input int vstep, input int force_at);
    int trig, last, idx, k;
    bit v, ok;
    trig = -1;
    if (force_at >= 0) trig = force_at;
    else begin
      for (int i = (pt > 1 ? pt : 1); i < stim.size(); i++) begin
        if (!fall && stim[i-1] < lvl && lvl <= stim[i]) begin trig = i; break; end
        if (fall && stim[i-1] >= lvl && lvl > stim[i]) begin trig = i; break; end
      end
    end
    last = trig + 255 - pt;
    if (trig < 0 || last >= stim.size()) begin
      bad++;
      $display("FAIL capture_setup: trig=%0d last=%0d stim=%0d", trig, last, stim.size());
      return;
    end
    sb.delete();
    for (int j = 0; j < 256; j++) sb.push_back(stim[trig - pt + j]);
    start_arm(pt, lvl, fall);
    idx = 0; k = 0; ok = 0;
    while (k < 20000) begin
      v = ((k % vstep) == 0) && (idx < stim.size());
      sample_valid = v;
      sample_in    = v ? stim[idx] : 8'($urandom);
      if (force_at < 0) force_trig = 1'b0;
      else if (vstep > 1) force_trig = ((k % vstep) == vstep - 1) && (idx == force_at);
      else force_trig = v && (idx == force_at);
      #1;
      total++;
      if (busy !== (idx <= last)) begin
        bad++; $display("FAIL cap_busy idx=%0d: got %b want %b", idx, busy, idx <= last);
      end
      total++;
      if (triggered !== (idx > trig)) begin
        bad++; $display("FAIL cap_triggered idx=%0d: got %b want %b", idx, triggered, idx > trig);
      end
      total++;
      if (ram_we !== (v && idx <= last)) begin
        bad++; $display("FAIL cap_we k=%0d idx=%0d: got %b want %b", k, idx, ram_we, v && idx <= last);
      end
      if (v && idx <= last) begin
        total++;
        if (ram_data_in !== stim[idx]) begin
          bad++; $display("FAIL cap_wdata idx=%0d: got %h want %h", idx, ram_data_in, stim[idx]);
        end
      end
      if (idx > last) begin
        total++;
        if (done !== 1'b1) begin
          bad++; $display("FAIL cap_done idx=%0d: got %b want 1", idx, done);
        end
        ok = 1;
        break;
      end
      if (v) idx++;
      k++;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    force_trig   = 1'b0;
    if (!ok) begin
      bad++; $display("FAIL cap_timeout: idx=%0d want past %0d", idx, last);
    end
  endtask

  // Drains n_stop samples from the readout port, popping sb on each handshake.
  task automatic run_readout(input bit toggle, input int n_stop);
    int n, cyc;
    bit stalled, ok;
    logic [7:0] held;
    n = 0; cyc = 0; stalled = 0; ok = 0; held = '0;
    @(negedge clk);
    while (cyc < 3000) begin
      if (n == n_stop) begin ok = 1; break; end
      rd_ready = toggle ? ((cyc % 3) != 1) : 1'b1;
      #1;
      total++;
      if ({rd_valid, done, triggered} !== 3'b111) begin
        bad++; $display("FAIL rd_status n=%0d: got %b want 111", n, {rd_valid, done, triggered});
      end
      total++;
      if (rd_data !== sb[0]) begin
        bad++; $display("FAIL rd_data n=%0d: got %h want %h", n, rd_data, sb[0]);
      end
      total++;
      if (rd_last !== (n == 255)) begin
        bad++; $display("FAIL rd_last n=%0d: got %b want %b", n, rd_last, n == 255);
      end
      if (stalled) begin
        total++;
        if (rd_data !== held) begin
          bad++; $display("FAIL rd_stall n=%0d: got %h want %h", n, rd_data, held);
        end
      end
      stalled = !rd_ready;
      held    = rd_data;
      if (rd_ready) begin void'(sb.pop_front()); n++; end
      cyc++;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    if (!ok) begin
      bad++; $display("FAIL rd_timeout: got %0d samples want %0d", n, n_stop);
    end else if (n_stop == 256) begin
      #1;
      total++;
      if ({done, rd_valid, rd_last, busy, triggered, ram_oe, ram_cs} !== 7'b0) begin
        bad++; $display("FAIL rd_end: got %b want 0000000",
                        {done, rd_valid, rd_last, busy, triggered, ram_oe, ram_cs});
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sample_valid = 1'b1; sample_in = 8'hA5; arm = 1'b1;
    force_trig = 1'b1; rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({ram_cs, ram_we, ram_oe, rd_valid, rd_last, busy, triggered, done} !== 8'b0) begin
      bad++; $display("FAIL reset_ctl: got %b want 0",
                      {ram_cs, ram_we, ram_oe, rd_valid, rd_last, busy, triggered, done});
    end
    total++;
    if ({ram_addr_in, ram_data_in, ram_addr_out, rd_data} !== 32'b0) begin
      bad++; $display("FAIL reset_bus: got %h want 0", {ram_addr_in, ram_data_in, ram_addr_out, rd_data});
    end
    @(negedge clk);
    rst_n = 1'b1; arm = 1'b0; force_trig = 1'b0; rd_ready = 1'b0;
    #1;
    total++;
    if ({ram_cs, ram_we, busy} !== 3'b0) begin
      bad++; $display("FAIL reset_idle: got %b want 000", {ram_cs, ram_we, busy});
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_pretrig_ramp;
    stim.delete();
    for (int i = 0; i < 600; i++) stim.push_back(8'(i));
    run_capture(16, 8'h80, 1'b0, 1, -1);
    run_readout(1'b0, 256);
  endtask

  task automatic test_circular;
    stim.delete();
    for (int i = 0; i < 1000; i++) stim.push_back(8'($urandom_range(0, 127)));
    for (int i = 0; i < 400; i++) stim.push_back(8'($urandom_range(128, 255)));
    run_capture(4, 8'h80, 1'b0, 1, -1);
    run_readout(1'b0, 256);
  endtask

  task automatic test_falling_sparse;
    stim.delete();
    for (int i = 0; i < 40; i++) stim.push_back(8'hC0 + 8'(i % 16));
    for (int i = 0; i < 300; i++) stim.push_back(8'((i * 7) % 64));
    run_capture(8, 8'h40, 1'b1, 3, -1);
    run_readout(1'b1, 256);
  endtask

  task automatic test_window_pre0;
    stim.delete();
    for (int i = 0; i < 300; i++) stim.push_back(8'($urandom_range(0, 254)));
    run_capture(0, 8'hFF, 1'b0, 2, 3);
    run_readout(1'b0, 256);
  endtask

  task automatic test_window_pre255;
    stim.delete();
    for (int i = 0; i < 300; i++) stim.push_back(8'($urandom_range(0, 127)));
    for (int i = 0; i < 300; i++) stim.push_back(8'($urandom_range(128, 255)));
    run_capture(255, 8'h80, 1'b0, 1, -1);
    run_readout(1'b1, 256);
  endtask

  task automatic test_abort_rearm;
    start_arm(2, 8'h80, 1'b0);
    step(1'b1, 8'h10); step(1'b1, 8'h20); step(1'b1, 8'h30);
    total++;
    if ({busy, triggered} !== 2'b10) begin
      bad++; $display("FAIL abort_armed_state: got %b want 10", {busy, triggered});
    end
    step(1'b1, 8'h90);
    abort = 1'b1; #1;
    total++;
    if (ram_we !== 1'b0) begin
      bad++; $display("FAIL abort_armed_we: got %b want 0", ram_we);
    end
    @(negedge clk); abort = 1'b0; sample_valid = 1'b0; #1;
    total++;
    if ({busy, triggered, done, ram_cs, rd_valid} !== 5'b0) begin
      bad++; $display("FAIL abort_armed_idle: got %b want 0", {busy, triggered, done, ram_cs, rd_valid});
    end

    start_arm(2, 8'h80, 1'b0);
    step(1'b1, 8'h10); step(1'b1, 8'h20); step(1'b1, 8'h30);
    step(1'b1, 8'h90); step(1'b1, 8'h91);
    total++;
    if ({busy, triggered} !== 2'b11) begin
      bad++; $display("FAIL abort_post_state: got %b want 11", {busy, triggered});
    end
    step(1'b1, 8'h92);
    abort = 1'b1; #1;
    total++;
    if (ram_we !== 1'b0) begin
      bad++; $display("FAIL abort_post_we: got %b want 0", ram_we);
    end
    @(negedge clk); abort = 1'b0; sample_valid = 1'b0; #1;
    total++;
    if ({busy, triggered, done, ram_cs, rd_valid} !== 5'b0) begin
      bad++; $display("FAIL abort_post_idle: got %b want 0", {busy, triggered, done, ram_cs, rd_valid});
    end

    stim.delete();
    for (int i = 0; i < 600; i++) stim.push_back(8'(i));
    run_capture(16, 8'h80, 1'b0, 1, -1);
    run_readout(1'b0, 100);
    arm = 1'b1; pretrig = 8'd3;
    @(negedge clk); arm = 1'b0; #1;
    total++;
    if ({done, busy, rd_valid} !== 3'b101) begin
      bad++; $display("FAIL arm_in_read: got %b want 101", {done, busy, rd_valid});
    end
    total++;
    if (rd_data !== sb[0]) begin
      bad++; $display("FAIL arm_in_read_data: got %h want %h", rd_data, sb[0]);
    end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0; #1;
    total++;
    if ({done, rd_valid, ram_oe, ram_cs, triggered, busy} !== 6'b0) begin
      bad++; $display("FAIL abort_read_idle: got %b want 0", {done, rd_valid, ram_oe, ram_cs, triggered, busy});
    end
    sb.delete();
    run_capture(5, 8'hC0, 1'b0, 1, -1);
    run_readout(1'b0, 256);
  endtask

  task automatic test_reset_post;
    start_arm(2, 8'h80, 1'b0);
    step(1'b1, 8'h10); step(1'b1, 8'h20); step(1'b1, 8'h30);
    step(1'b1, 8'h90); step(1'b1, 8'h91);
    step(1'b1, 8'h92);
    rst_n = 1'b0; #1;
    total++;
    if (ram_we !== 1'b0) begin
      bad++; $display("FAIL rst_post_we: got %b want 0", ram_we);
    end
    @(negedge clk); rst_n = 1'b1; sample_valid = 1'b0; #1;
    total++;
    if ({ram_cs, ram_we, ram_oe, rd_valid, rd_last, busy, triggered, done} !== 8'b0) begin
      bad++; $display("FAIL rst_post_ctl: got %b want 0",
                      {ram_cs, ram_we, ram_oe, rd_valid, rd_last, busy, triggered, done});
    end
    total++;
    if ({ram_addr_in, ram_data_in, ram_addr_out, rd_data} !== 32'b0) begin
      bad++; $display("FAIL rst_post_bus: got %h want 0", {ram_addr_in, ram_data_in, ram_addr_out, rd_data});
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    force_trig = 1'b0; trig_level = '0; trig_falling = 1'b0; pretrig = '0; rd_ready = 1'b0;
    test_reset();
    test_pretrig_ramp();
    test_circular();
    test_falling_sparse();
    test_window_pre0();
    test_window_pre255();
    test_abort_rearm();
    test_reset_post();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
